// File: rtl/pattern_det_ctrl_if.sv
// Configuration handshake bundle between the host side and the
// pattern detector run controller.
interface pattern_det_ctrl_if #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 16,
    parameter int WIN_W   = 16
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_target;
    logic [WIN_W-1:0]   cfg_window;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len,
        output cfg_overlap, cfg_target, cfg_window,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len,
        input  cfg_overlap, cfg_target, cfg_window,
        output cfg_ready
    );
endinterface

// File: rtl/pattern_det_ctrl.sv
// Run controller for the serial pattern detector: config shadowing,
// detector clear/enable sequencing, hit counting and run termination.
module pattern_det_ctrl #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 16,
    parameter int WIN_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    pattern_det_ctrl_if.slave  cfg,
    input  logic               start,
    input  logic               abort,
    input  logic               data_valid,
    input  logic               det_hit,
    output logic [MAX_LEN-1:0] det_pattern,
    output logic [LEN_W-1:0]   det_len,
    output logic               det_overlap,
    output logic               det_clr,
    output logic               det_en,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic               cfg_err,
    output logic [CNT_W-1:0]   hit_count
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             cfg_loaded;
    logic [CNT_W-1:0] target_q;
    logic [WIN_W-1:0] window_q;
    logic [WIN_W-1:0] win_cnt;

    logic             acc;
    logic             legal;
    logic             start_ok;
    logic             hit_reach;
    logic             win_reach;
    logic [CNT_W-1:0] hit_inc;
    logic [WIN_W-1:0] win_inc;

    assign cfg.cfg_ready = (state == IDLE) || (state == DONE);
    assign acc      = cfg.cfg_valid & cfg.cfg_ready;
    assign legal    = (cfg.cfg_len != '0) &&
                      (cfg.cfg_len <= LEN_W'(MAX_LEN));
    // A config accepted alongside start is usable for that same run
    assign start_ok = start & (cfg_loaded | (acc & legal));

    assign hit_inc   = (&hit_count) ? hit_count : hit_count + 1'b1;
    assign win_inc   = win_cnt + 1'b1;
    assign hit_reach = det_hit && (target_q != '0) &&
                       (hit_inc == target_q);
    assign win_reach = data_valid && (window_q != '0) &&
                       (win_inc == window_q);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (!abort && start_ok) state_nx = CLEAR;
            CLEAR: state_nx = abort ? IDLE : RUN;
            RUN: begin
                if (abort)
                    state_nx = IDLE;
                else if (hit_reach || win_reach)
                    state_nx = DONE;
            end
            DONE: begin
                if (abort)
                    state_nx = IDLE;
                else if (start_ok)
                    state_nx = CLEAR;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cfg_loaded  <= 1'b0;
            target_q    <= '0;
            window_q    <= '0;
            win_cnt     <= '0;
            det_pattern <= '0;
            det_len     <= '0;
            det_overlap <= 1'b0;
            det_clr     <= 1'b0;
            det_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cfg_err     <= 1'b0;
            hit_count   <= '0;
        end else begin
            state   <= state_nx;
            det_clr <= (state_nx == CLEAR);
            det_en  <= (state_nx == RUN);
            busy    <= (state_nx == CLEAR) || (state_nx == RUN);

            if (acc) begin
                if (legal) begin
                    det_pattern <= cfg.cfg_pattern;
                    det_len     <= cfg.cfg_len;
                    det_overlap <= cfg.cfg_overlap;
                    target_q    <= cfg.cfg_target;
                    window_q    <= cfg.cfg_window;
                    cfg_loaded  <= 1'b1;
                    cfg_err     <= 1'b0;
                end else begin
                    cfg_err     <= 1'b1;
                end
            end

            if (state_nx == CLEAR) begin
                hit_count <= '0;
                win_cnt   <= '0;
                done      <= 1'b0;
                timeout   <= 1'b0;
            end else if (abort && state != IDLE) begin
                done      <= 1'b0;
                timeout   <= 1'b0;
            end else if (state == RUN) begin
                if (data_valid)
                    win_cnt <= win_inc;
                if (det_hit)
                    hit_count <= hit_inc;
                // Hit target wins over a coincident window expiry
                if (hit_reach || win_reach) begin
                    done    <= hit_reach;
                    timeout <= win_reach & ~hit_reach;
                end
            end else if (acc && legal && state == DONE) begin
                done      <= 1'b0;
                timeout   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Self-checking bench for pattern_det_ctrl with a behavioural detector
// and an event-level reference model of the run controller.
module tb_pattern_det_ctrl;
    localparam int MAX_LEN = 16;
    localparam int LEN_W   = 5;
    localparam int CNT_W   = 16;
    localparam int WIN_W   = 16;

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic rst;
    logic start, abort, data_valid, det_hit;
    logic sbit, det_force, dmatch;
    logic [MAX_LEN-1:0] det_pattern;
    logic [LEN_W-1:0]   det_len;
    logic               det_overlap, det_clr, det_en;
    logic               busy, done, timeout, cfg_err;
    logic [CNT_W-1:0]   hit_count;

    pattern_det_ctrl_if #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
        .CNT_W(CNT_W), .WIN_W(WIN_W)
    ) cfg_if ();

    pattern_det_ctrl #(
        .MAX_LEN(MAX_LEN), .LEN_W(LEN_W),
        .CNT_W(CNT_W), .WIN_W(WIN_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg(cfg_if),
        .start(start),
        .abort(abort),
        .data_valid(data_valid),
        .det_hit(det_hit),
        .det_pattern(det_pattern),
        .det_len(det_len),
        .det_overlap(det_overlap),
        .det_clr(det_clr),
        .det_en(det_en),
        .busy(busy),
        .done(done),
        .timeout(timeout),
        .cfg_err(cfg_err),
        .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, act, exp, $time);
        end
    endtask

    // Behavioural detector: history of bits since last clear, hit
    // flagged in the cycle the completing bit is presented
    logic [15:0] dsh;
    int          dnb;

    function automatic logic pat_match(logic [15:0] h, int n, logic b,
                                       logic [15:0] p, int l);
        int hv, m;
        if (l == 0 || n + 1 < l) return 1'b0;
        hv = (int'(h) << 1) | int'(b);
        m  = (1 << l) - 1;
        return (hv & m) == (int'(p) & m);
    endfunction

    assign dmatch  = pat_match(dsh, dnb, sbit, det_pattern, int'(det_len));
    assign det_hit = det_force | (det_en & data_valid & dmatch);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dsh <= '0;
            dnb <= 0;
        end else if (det_clr) begin
            dsh <= '0;
            dnb <= 0;
        end else if (det_en && data_valid) begin
            dsh <= {dsh[14:0], sbit};
            if (dmatch && !det_overlap)
                dnb <= 0;
            else
                dnb <= (dnb < 16) ? dnb + 1 : 16;
        end
    end

    // Reference model state
    int m_mode, m_pat, m_len, m_tgt, m_win, m_hits, m_bits;
    bit m_loaded, m_ovl, m_err, m_done, m_to;
    logic last_hit;

    task automatic model_reset();
        m_mode = M_IDLE; m_pat = 0; m_len = 0; m_tgt = 0; m_win = 0;
        m_hits = 0; m_bits = 0; m_loaded = 0; m_ovl = 0; m_err = 0;
        m_done = 0; m_to = 0;
    endtask

    task automatic model_step();
        bit ready, acc, legal, hit, t, w;
        int nmode;
        ready = (m_mode == M_IDLE) || (m_mode == M_DONE);
        acc   = cfg_if.cfg_valid && ready;
        legal = cfg_if.cfg_len >= 1 && cfg_if.cfg_len <= MAX_LEN;
        hit   = (det_hit === 1'b1);
        nmode = m_mode;
        if (acc) begin
            if (legal) begin
                m_pat = int'(cfg_if.cfg_pattern);
                m_len = int'(cfg_if.cfg_len);
                m_ovl = cfg_if.cfg_overlap;
                m_tgt = int'(cfg_if.cfg_target);
                m_win = int'(cfg_if.cfg_window);
                m_loaded = 1; m_err = 0;
                if (m_mode == M_DONE) begin m_done = 0; m_to = 0; end
            end else begin
                m_err = 1;
            end
        end
        if (abort) begin
            if (m_mode != M_IDLE) begin
                nmode = M_IDLE; m_done = 0; m_to = 0;
            end
        end else if (m_mode == M_CLEAR) begin
            nmode = M_RUN;
        end else if (m_mode == M_RUN) begin
            if (data_valid) m_bits = (m_bits + 1) % 65536;
            if (hit && m_hits < 65535) m_hits++;
            t = hit && m_tgt != 0 && m_hits == m_tgt;
            w = data_valid && m_win != 0 && m_bits == m_win;
            if (t || w) begin
                nmode = M_DONE; m_done = t; m_to = w && !t;
            end
        end else if (start && m_loaded) begin
            nmode = M_CLEAR;
            m_hits = 0; m_bits = 0; m_done = 0; m_to = 0;
        end
        m_mode = nmode;
    endtask

    task automatic compare_all();
        chk("cfg_ready", 32'(cfg_if.cfg_ready),
            32'(m_mode == M_IDLE || m_mode == M_DONE));
        chk("det_pattern", 32'(det_pattern), m_pat);
        chk("det_len", 32'(det_len), m_len);
        chk("det_overlap", 32'(det_overlap), 32'(m_ovl));
        chk("det_clr", 32'(det_clr), 32'(m_mode == M_CLEAR));
        chk("det_en", 32'(det_en), 32'(m_mode == M_RUN));
        chk("busy", 32'(busy),
            32'(m_mode == M_CLEAR || m_mode == M_RUN));
        chk("done", 32'(done), 32'(m_done));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
        chk("hit_count", 32'(hit_count), m_hits);
    endtask

    task automatic tick();
        #1;
        last_hit = det_hit;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic load_cfg(input logic [15:0] pat, input int len,
                            input logic ovl, input int tgt, input int win);
        cfg_if.cfg_valid   = 1'b1;
        cfg_if.cfg_pattern = pat;
        cfg_if.cfg_len     = LEN_W'(len);
        cfg_if.cfg_overlap = ovl;
        cfg_if.cfg_target  = CNT_W'(tgt);
        cfg_if.cfg_window  = WIN_W'(win);
        tick();
        cfg_if.cfg_valid   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] bits, input int n,
                        output logic [31:0] hm);
        hm = '0;
        for (int i = 0; i < n; i++) begin
            data_valid = 1'b1;
            sbit = bits[n-1-i];
            tick();
            if (last_hit === 1'b1) hm[i+1] = 1'b1;
        end
        data_valid = 1'b0;
        sbit = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] hm;
        rst = 1'b0;
        start = 1'b0; abort = 1'b0; data_valid = 1'b0;
        sbit = 1'b0; det_force = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_pattern = '0;
        cfg_if.cfg_len = '0; cfg_if.cfg_overlap = 1'b0;
        cfg_if.cfg_target = '0; cfg_if.cfg_window = '0;
        model_reset();
        #12;
        compare_all();
        @(posedge clk);
        #2 rst = 1'b1;

        // Illegal lengths leave the shadow untouched; start then ignored
        load_cfg(16'hBEEF, 0, 1'b1, 1, 1);
        chk("len0_err", 32'(cfg_err), 1);
        chk("len0_len", 32'(det_len), 0);
        load_cfg(16'h1234, 17, 1'b0, 2, 2);
        chk("len17_err", 32'(cfg_err), 1);
        chk("len17_len", 32'(det_len), 0);
        pulse_start();
        chk("nocfg_busy", 32'(busy), 0);
        chk("nocfg_clr", 32'(det_clr), 0);

        // 11-bit pattern, window 11: single hit on the last bit
        load_cfg(16'b10110110110, 11, 1'b1, 0, 11);
        chk("t1_err", 32'(cfg_err), 0);
        pulse_start();
        chk("t1_clr", 32'(det_clr), 1);
        tick();
        chk("t1_en", 32'(det_en), 1);
        feed(16'b10110110110, 11, hm);
        chk("t1_hits", hm, 32'h800);
        chk("t1_count", 32'(hit_count), 1);
        chk("t1_timeout", 32'(timeout), 1);
        chk("t1_done", 32'(done), 0);
        chk("t1_en_off", 32'(det_en), 0);

        // Overlapping 1011, target 3
        load_cfg(16'b1011, 4, 1'b1, 3, 0);
        chk("t3_done_clr", 32'(done), 0);
        pulse_start();
        tick();
        feed(16'b1011011011, 10, hm);
        chk("t3_hitpos", hm, 32'h490);
        chk("t3_done", 32'(done), 1);
        chk("t3_count", 32'(hit_count), 3);
        chk("t3_timeout", 32'(timeout), 0);

        // Target and window expiring together: done wins
        load_cfg(16'b101, 3, 1'b0, 2, 7);
        pulse_start();
        tick();
        feed(16'b1010101, 7, hm);
        chk("t4_hitpos", hm, 32'h88);
        chk("t4_done", 32'(done), 1);
        chk("t4_timeout", 32'(timeout), 0);
        chk("t4_count", 32'(hit_count), 2);

        // Abort mid-run, then restart
        load_cfg(16'b1011, 4, 1'b1, 0, 0);
        pulse_start();
        tick();
        feed(16'b10110, 5, hm);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_en", 32'(det_en), 0);
        chk("ab_done", 32'(done), 0);
        chk("ab_timeout", 32'(timeout), 0);
        chk("ab_count", 32'(hit_count), 1);
        pulse_start();
        chk("ab_clr", 32'(det_clr), 1);
        chk("ab_count0", 32'(hit_count), 0);
        tick();

        // Asynchronous reset mid-run with det_hit high
        feed(16'b101, 3, hm);
        det_force = 1'b1;
        #1 rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("rst_en", 32'(det_en), 0);
        chk("rst_len", 32'(det_len), 0);
        det_force = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        pulse_start();
        chk("rst_nostart", 32'(busy), 0);

        // Randomized traffic against the model
        for (int c = 0; c < 900; c++) begin
            cfg_if.cfg_valid   = ($urandom % 6) == 0;
            cfg_if.cfg_pattern = 16'($urandom);
            cfg_if.cfg_len     = LEN_W'($urandom_range(0, 17));
            cfg_if.cfg_overlap = 1'($urandom);
            cfg_if.cfg_target  = CNT_W'($urandom_range(0, 4));
            cfg_if.cfg_window  = WIN_W'($urandom_range(0, 24));
            start      = ($urandom % 6) == 0;
            abort      = ($urandom % 40) == 0;
            data_valid = ($urandom % 4) != 0;
            sbit       = 1'($urandom);
            det_force  = ($urandom % 25) == 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pattern_det_ctrl.md
Name: pattern_det_ctrl

Overview:
Run controller for the programmable serial pattern detector.
- Accepts a pattern configuration through a valid/ready handshake, drives it onto the detector's static config inputs, and clears the detector.
- Arms the detector for a measurement run, counts detector hits over a bounded bit window, and stops on hit target, window expiry or abort.
- Sits between the host/config logic and the detector instance; the serial data stream goes directly to the detector, qualified by data_valid.

Parameters:
MAX_LEN, 16, maximum pattern length in bits
LEN_W, 5, width of length fields; must hold MAX_LEN
CNT_W, 16, width of the hit counter and hit target
WIN_W, 16, width of the bit-window counter and window limit

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-low reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  configuration accepted when high with cfg_valid
cfg_pattern  input  MAX_LEN  pattern bits, MSB-first matched, right-aligned in LSBs
cfg_len  input  LEN_W  pattern length, legal range 1..MAX_LEN
cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
cfg_target  input  CNT_W  hit count ending the run; 0 = unlimited
cfg_window  input  WIN_W  number of valid bits per run; 0 = unlimited
start  input  1  begin run, single-cycle pulse
abort  input  1  terminate run and return to IDLE
data_valid  input  1  a stream bit is presented to the detector this cycle
det_hit  input  1  detector match pulse, registered by detector
det_pattern  output  MAX_LEN  pattern driven to detector
det_len  output  LEN_W  length driven to detector
det_overlap  output  1  overlap mode driven to detector
det_clr  output  1  detector history clear, one cycle
det_en  output  1  detector enable
busy  output  1  CLEAR or RUN state
done  output  1  run ended by reaching the hit target
timeout  output  1  run ended by window expiry
cfg_err  output  1  last offered configuration was illegal
hit_count  output  CNT_W  hits counted in the current/last run

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE.
  - det_pattern, det_len, det_overlap, det_clr, det_en, busy, done, timeout, cfg_err, hit_count and window counter all 0.
  - Internal cfg_loaded = 0.
- States: IDLE, CLEAR, RUN, DONE.
- cfg_ready = 1 in IDLE and DONE, 0 in CLEAR and RUN.
- Config handshake (cfg_valid & cfg_ready):
  - If cfg_len is 0 or greater than MAX_LEN: shadow registers unchanged, cfg_err = 1.
  - Otherwise: latch all cfg_* fields next edge, drive them onto det_*, cfg_loaded = 1, cfg_err = 0.
  - Accepting a config in DONE clears done and timeout; state stays DONE.
- IDLE/DONE -> CLEAR: on start with cfg_loaded = 1.
  - start without cfg_loaded is ignored.
  - start in CLEAR or RUN is ignored.
  - start and config acceptance in the same cycle: the config is latched first and used for the run.
- CLEAR (exactly 1 cycle):
  - det_clr = 1, det_en = 0, busy = 1.
  - hit_count, window counter, done and timeout cleared.
  - Next state RUN.
- RUN:
  - det_en = 1, busy = 1.
  - Window counter increments on each data_valid cycle.
  - hit_count increments on each det_hit cycle and saturates at all-ones.
  - det_hit outside RUN is ignored.
- Hit target: when cfg_target != 0 and the hit increment makes hit_count == cfg_target, go to DONE and set done = 1 next edge.
- Window expiry: when cfg_window != 0 and the increment makes the window count == cfg_window, go to DONE and set timeout = 1.
  - A det_hit in that same cycle is still counted.
- Target and window expiry in the same cycle: done = 1, timeout = 0.
- Abort:
  - In CLEAR, RUN or DONE: next state IDLE; done and timeout cleared; hit_count retained; det_en = 0.
  - Abort has priority over start, target and window in the same cycle.
  - Configuration is retained (cfg_loaded unchanged).
- DONE:
  - det_en = 0, busy = 0.
  - hit_count, done and timeout held until the next CLEAR, a config acceptance, or abort.
- det_* config outputs change only on config acceptance, never during CLEAR or RUN.
- All outputs are registered. Latency:
  - start to det_clr: 1 cycle.
  - det_clr to det_en: 1 cycle.
  - Terminating det_hit or data_valid to done/timeout: 1 cycle.

Test Plan:
- Detector modelled behaviourally in the bench.
  - Config pattern 11'b10110110110, len 11, overlap 1, target 0, window 11.
  - Start, then feed the pattern MSB-first with data_valid = 1.
  - Required: one det_hit, hit_count = 1, timeout = 1 after the 11th bit, done = 0, det_en low in DONE.
- Config len 0, then len 17 (MAX_LEN = 16): cfg_err = 1 each time, det_len unchanged.
  - Then start: ignored, state stays IDLE, busy = 0.
- Pattern 4'b1011, target 3, window 0, overlap 1; stream 1011011011.
  - Required: hits at bits 4, 7, 10; done = 1 one cycle after the third hit; hit_count = 3; timeout = 0.
- Target 2, window 7, overlap 0; stream arranged so the 2nd hit lands on the 7th valid bit.
  - Required: done = 1, timeout = 0, hit_count = 2.
- Mid-RUN abort after 5 bits: next cycle IDLE, det_en = 0, busy = 0, done = timeout = 0.
  - Then a new start: det_clr pulses and hit_count resets to 0.
- Assert rst low mid-RUN with det_hit high: all outputs 0 immediately (asynchronously).
  - After release: start without a new config is ignored (cfg_loaded = 0).
